// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller.
// A debouncer turns the keypad scanner's one-hot key vector into single-cycle
// key events. A four-state FSM (MAIN / PLAY / CHECK / RESULT) owns the board,
// turn, display shift and result state that feed the display stages.
module ttt_game_ctrl #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned RESULT_HOLD = 5000,
  parameter bit          FIRST_O     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_data,
  output logic [17:0] board,
  output logic        is_main,
  output logic        is_turn_o,
  output logic        is_right,
  output logic [1:0]  winner,
  output logic [8:0]  win_line,
  output logic [3:0]  move_cnt,
  output logic        place_err
);

  localparam int unsigned CNT_W     = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HOLD_W    = (RESULT_HOLD < 2) ? 1 : $clog2(RESULT_HOLD);
  localparam int unsigned HOLD_LAST = (RESULT_HOLD == 0) ? 0 : RESULT_HOLD - 1;

  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEB_FULL = CNT_W'(DEB_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_LAST);

  localparam logic [3:0] KEY_STAR = 4'd9;
  localparam logic [3:0] KEY_ZERO = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Cell masks of the 8 lines, 9 bits each: rows, columns, then diagonals.
  localparam logic [71:0] LINES = {9'h054, 9'h111, 9'h124, 9'h092,
                                   9'h049, 9'h1C0, 9'h038, 9'h007};

  typedef enum logic [1:0] {
    S_MAIN   = 2'd0,
    S_PLAY   = 2'd1,
    S_CHECK  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // Position of the single set bit of a one-hot key vector.
  function automatic logic [3:0] key_index(input logic [11:0] k);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 12; i++) begin
      if (k[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Content of cell idx; keys outside 0..8 read as empty.
  function automatic logic [1:0] cell_get(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] v;
    v = 2'd0;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) v = b[2*i +: 2];
    end
    return v;
  endfunction

  // Board with cell idx overwritten by stone p.
  function automatic logic [17:0] cell_set(input logic [17:0] b, input logic [3:0] idx,
                                           input logic [1:0] p);
    logic [17:0] r;
    r = b;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) r[2*i +: 2] = p;
    end
    return r;
  endfunction

  // OR of the masks of every line fully owned by player p.
  function automatic logic [8:0] line_hits(input logic [17:0] b, input logic [1:0] p);
    logic [8:0] mine;
    logic [8:0] hits;
    logic [8:0] m;
    hits = '0;
    for (int i = 0; i < 9; i++) mine[i] = (b[2*i +: 2] == p);
    for (int l = 0; l < 8; l++) begin
      m = LINES[9*l +: 9];
      if ((mine & m) == m) hits = hits | m;
    end
    return hits;
  endfunction

  logic [11:0]       key_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              armed_q;
  logic              ev_q;
  logic [3:0]        ev_key_q;

  state_t            state_q;
  logic [17:0]       board_q;
  logic              is_main_q;
  logic              turn_o_q;
  logic              right_q;
  logic [1:0]        winner_q;
  logic [8:0]        win_line_q;
  logic [3:0]        move_cnt_q;
  logic              place_err_q;
  logic [HOLD_W-1:0] hold_q;

  logic [1:0]        mover;
  logic [8:0]        hits;
  logic              ev_is_cell;
  logic              cell_free;
  logic [17:0]       board_placed;

  // Debounce: restart the stability count on any input change; fire once per
  // press when armed, re-arm only after a stable all-zero vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q    <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      ev_q     <= 1'b0;
      ev_key_q <= '0;
    end else begin
      ev_q <= 1'b0;
      if (key_data != key_q) begin
        key_q <= key_data;
        cnt_q <= CNT_W'(1);
      end else begin
        if (cnt_q != DEB_FULL) cnt_q <= cnt_q + CNT_W'(1);
        if (armed_q && $onehot(key_q) && (cnt_q == DEB_LAST)) begin
          ev_q     <= 1'b1;
          ev_key_q <= key_index(key_q);
          armed_q  <= 1'b0;
        end else if (!armed_q && (key_q == 12'h000) && (cnt_q >= DEB_LAST)) begin
          armed_q <= 1'b1;
        end
      end
    end
  end

  // Decode of the current event against the board and the player to move.
  always_comb begin
    mover        = turn_o_q ? 2'd2 : 2'd1;
    hits         = line_hits(board_q, mover);
    ev_is_cell   = (ev_key_q < 4'd9);
    cell_free    = (cell_get(board_q, ev_key_q) == 2'd0);
    board_placed = cell_set(board_q, ev_key_q, mover);
  end

  // Game FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_MAIN;
      board_q     <= '0;
      is_main_q   <= 1'b1;
      turn_o_q    <= FIRST_O;
      right_q     <= 1'b0;
      winner_q    <= 2'd0;
      win_line_q  <= '0;
      move_cnt_q  <= '0;
      place_err_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      place_err_q <= 1'b0;
      if (ev_q && (ev_key_q == KEY_HASH)) begin
        state_q    <= S_MAIN;
        is_main_q  <= 1'b1;
        board_q    <= '0;
        move_cnt_q <= '0;
        winner_q   <= 2'd0;
        win_line_q <= '0;
        hold_q     <= '0;
      end else begin
        unique case (state_q)
          S_MAIN: begin
            if (ev_q && (ev_key_q == KEY_ZERO)) begin
              state_q    <= S_PLAY;
              is_main_q  <= 1'b0;
              board_q    <= '0;
              move_cnt_q <= '0;
              winner_q   <= 2'd0;
              win_line_q <= '0;
              turn_o_q   <= FIRST_O;
            end else if (ev_q && (ev_key_q == KEY_STAR)) begin
              right_q <= ~right_q;
            end
          end
          S_PLAY: begin
            if (ev_q && ev_is_cell) begin
              if (cell_free) begin
                board_q    <= board_placed;
                move_cnt_q <= move_cnt_q + 4'd1;
                state_q    <= S_CHECK;
              end else begin
                place_err_q <= 1'b1;
              end
            end else if (ev_q && (ev_key_q == KEY_STAR)) begin
              right_q <= ~right_q;
            end
          end
          S_CHECK: begin
            // A completed line wins even when it is also the ninth stone.
            if (hits != 9'h000) begin
              state_q    <= S_RESULT;
              winner_q   <= mover;
              win_line_q <= hits;
              hold_q     <= '0;
            end else if (move_cnt_q == 4'd9) begin
              state_q    <= S_RESULT;
              winner_q   <= 2'd3;
              win_line_q <= '0;
              hold_q     <= '0;
            end else begin
              turn_o_q <= ~turn_o_q;
              state_q  <= S_PLAY;
            end
          end
          S_RESULT: begin
            if (ev_q && (ev_key_q == KEY_ZERO)) begin
              state_q    <= S_PLAY;
              board_q    <= '0;
              move_cnt_q <= '0;
              winner_q   <= 2'd0;
              win_line_q <= '0;
              turn_o_q   <= FIRST_O;
              hold_q     <= '0;
            end else begin
              if (ev_q && (ev_key_q == KEY_STAR)) right_q <= ~right_q;
              if (RESULT_HOLD != 0) begin
                if (hold_q == HOLD_END) begin
                  state_q    <= S_MAIN;
                  is_main_q  <= 1'b1;
                  board_q    <= '0;
                  move_cnt_q <= '0;
                  winner_q   <= 2'd0;
                  win_line_q <= '0;
                  hold_q     <= '0;
                end else begin
                  hold_q <= hold_q + HOLD_W'(1);
                end
              end
            end
          end
          default: begin
            state_q   <= S_MAIN;
            is_main_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign board     = board_q;
  assign is_main   = is_main_q;
  assign is_turn_o = turn_o_q;
  assign is_right  = right_q;
  assign winner    = winner_q;
  assign win_line  = win_line_q;
  assign move_cnt  = move_cnt_q;
  assign place_err = place_err_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: hand-written reset/debounce sequences
// followed by a table of key presses with hand-computed expected state.
module tb_ttt_game_ctrl;

  localparam int DEB  = 16;
  localparam int HOLD = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] key_data;
  logic [17:0] board;
  logic        is_main;
  logic        is_turn_o;
  logic        is_right;
  logic [1:0]  winner;
  logic [8:0]  win_line;
  logic [3:0]  move_cnt;
  logic        place_err;

  ttt_game_ctrl #(.DEB_CYCLES(DEB), .RESULT_HOLD(HOLD), .FIRST_O(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_data  (key_data),
    .board     (board),
    .is_main   (is_main),
    .is_turn_o (is_turn_o),
    .is_right  (is_right),
    .winner    (winner),
    .win_line  (win_line),
    .move_cnt  (move_cnt),
    .place_err (place_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] key;
    int          hold;
    int          rel;
    logic [17:0] brd;
    logic        mn;
    logic        tn;
    logic [1:0]  wn;
    logic [8:0]  ln;
    logic [3:0]  mv;
    logic        rt;
    int          perr;
    bit          turn_dc;
    bit          res_dc;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int perr_total = 0;
  int perr_start = 0;
  vec_t tv[$];

  // Cycles with place_err high, sampled mid-cycle.
  always @(negedge clk) if (place_err === 1'b1) perr_total++;

  function automatic logic [11:0] kn(input int n);
    logic [11:0] one;
    one = 12'h001;
    return one << (n - 1);
  endfunction

  function automatic vec_t mk(input logic [11:0] key, input int hold, input int rel,
                              input logic [17:0] brd, input logic mn, input logic tn,
                              input logic [1:0] wn, input logic [8:0] ln,
                              input logic [3:0] mv, input logic rt, input int perr,
                              input bit turn_dc, input bit res_dc);
    vec_t v;
    v.key = key; v.hold = hold; v.rel = rel; v.brd = brd; v.mn = mn; v.tn = tn;
    v.wn = wn; v.ln = ln; v.mv = mv; v.rt = rt; v.perr = perr;
    v.turn_dc = turn_dc; v.res_dc = res_dc;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive key k for h cycles, then all-zero for r cycles; ends on a falling edge.
  task automatic apply(input logic [11:0] k, input int h, input int r);
    key_data = k;
    repeat (h) @(negedge clk);
    key_data = 12'h000;
    repeat (r) @(negedge clk);
  endtask

  task automatic check_vec(input string tag, input vec_t v, input int perr);
    cmp({tag, " board"}, 32'(board), 32'(v.brd));
    cmp({tag, " is_main"}, 32'(is_main), 32'(v.mn));
    cmp({tag, " is_right"}, 32'(is_right), 32'(v.rt));
    cmp({tag, " place_err"}, 32'(perr), 32'(v.perr));
    if (!v.turn_dc) cmp({tag, " is_turn_o"}, 32'(is_turn_o), 32'(v.tn));
    if (!v.res_dc) begin
      cmp({tag, " winner"}, 32'(winner), 32'(v.wn));
      cmp({tag, " win_line"}, 32'(win_line), 32'(v.ln));
      cmp({tag, " move_cnt"}, 32'(move_cnt), 32'(v.mv));
    end
  endtask

  initial begin
    // key, hold, rel, board, main, turn, winner, line, moves, right, perr, turn_dc, res_dc
    // Start: PLAY, O on cell 4 (key 5), X to move.
    tv.push_back(mk(kn(5), 20, 24, 18'h00200, 0, 0, 0, 9'h000, 1, 0, 1, 0, 0));
    tv.push_back(mk(kn(10), 20, 24, 18'h00200, 0, 0, 0, 9'h000, 1, 1, 0, 0, 0));
    tv.push_back(mk(kn(10), 20, 24, 18'h00200, 0, 0, 0, 9'h000, 1, 0, 0, 0, 0));
    tv.push_back(mk(kn(12), 20, 24, 18'h00000, 1, 0, 0, 9'h000, 0, 0, 0, 1, 0));
    tv.push_back(mk(kn(11), 20, 24, 18'h00000, 0, 1, 0, 9'h000, 0, 0, 0, 0, 0));
    // O:1 X:4 O:2 X:5 O:3 -> O wins on the top row.
    tv.push_back(mk(kn(1), 20, 24, 18'h00002, 0, 0, 0, 9'h000, 1, 0, 0, 0, 0));
    tv.push_back(mk(kn(4), 20, 24, 18'h00042, 0, 1, 0, 9'h000, 2, 0, 0, 0, 0));
    tv.push_back(mk(kn(2), 20, 24, 18'h0004A, 0, 0, 0, 9'h000, 3, 0, 0, 0, 0));
    tv.push_back(mk(kn(5), 20, 24, 18'h0014A, 0, 1, 0, 9'h000, 4, 0, 0, 0, 0));
    tv.push_back(mk(kn(3), 20, 24, 18'h0016A, 0, 1, 2, 9'h007, 5, 0, 0, 0, 0));
    tv.push_back(mk(kn(9), 20, 24, 18'h0016A, 0, 1, 2, 9'h007, 5, 0, 0, 0, 0));
    tv.push_back(mk(kn(8), 20, 24, 18'h0016A, 0, 1, 2, 9'h007, 5, 0, 0, 0, 0));
    tv.push_back(mk(kn(11), 20, 24, 18'h00000, 0, 1, 0, 9'h000, 0, 0, 0, 0, 0));
    // Draw: O0 X1 O2 X4 O3 X5 O7 X6 O8.
    tv.push_back(mk(kn(1), 20, 24, 18'h00002, 0, 0, 0, 9'h000, 1, 0, 0, 0, 0));
    tv.push_back(mk(kn(2), 20, 24, 18'h00006, 0, 1, 0, 9'h000, 2, 0, 0, 0, 0));
    tv.push_back(mk(kn(3), 20, 24, 18'h00026, 0, 0, 0, 9'h000, 3, 0, 0, 0, 0));
    tv.push_back(mk(kn(5), 20, 24, 18'h00126, 0, 1, 0, 9'h000, 4, 0, 0, 0, 0));
    tv.push_back(mk(kn(4), 20, 24, 18'h001A6, 0, 0, 0, 9'h000, 5, 0, 0, 0, 0));
    tv.push_back(mk(kn(6), 20, 24, 18'h005A6, 0, 1, 0, 9'h000, 6, 0, 0, 0, 0));
    tv.push_back(mk(kn(8), 20, 24, 18'h085A6, 0, 0, 0, 9'h000, 7, 0, 0, 0, 0));
    tv.push_back(mk(kn(7), 20, 24, 18'h095A6, 0, 1, 0, 9'h000, 8, 0, 0, 0, 0));
    tv.push_back(mk(kn(9), 20, 24, 18'h295A6, 0, 1, 3, 9'h000, 9, 0, 0, 0, 0));
    // RESULT entered 18 cycles after key 9 went high; it lasts HOLD cycles.
    tv.push_back(mk(12'h000, 146, 24, 18'h295A6, 0, 1, 3, 9'h000, 9, 0, 0, 0, 0));
    tv.push_back(mk(12'h000, 0, 8, 18'h00000, 1, 0, 0, 9'h000, 0, 0, 0, 1, 1));
    // New game; O wins with the ninth stone: O0 X3 O1 X4 O5 X7 O6 X8 O2.
    tv.push_back(mk(kn(11), 20, 24, 18'h00000, 0, 1, 0, 9'h000, 0, 0, 0, 0, 0));
    tv.push_back(mk(kn(1), 20, 24, 18'h00002, 0, 0, 0, 9'h000, 1, 0, 0, 0, 0));
    tv.push_back(mk(kn(4), 20, 24, 18'h00042, 0, 1, 0, 9'h000, 2, 0, 0, 0, 0));
    tv.push_back(mk(kn(2), 20, 24, 18'h0004A, 0, 0, 0, 9'h000, 3, 0, 0, 0, 0));
    tv.push_back(mk(kn(5), 20, 24, 18'h0014A, 0, 1, 0, 9'h000, 4, 0, 0, 0, 0));
    tv.push_back(mk(kn(6), 20, 24, 18'h0094A, 0, 0, 0, 9'h000, 5, 0, 0, 0, 0));
    tv.push_back(mk(kn(8), 20, 24, 18'h0494A, 0, 1, 0, 9'h000, 6, 0, 0, 0, 0));
    tv.push_back(mk(kn(7), 20, 24, 18'h0694A, 0, 0, 0, 9'h000, 7, 0, 0, 0, 0));
    tv.push_back(mk(kn(9), 20, 24, 18'h1694A, 0, 1, 0, 9'h000, 8, 0, 0, 0, 0));
    tv.push_back(mk(kn(3), 20, 24, 18'h1696A, 0, 1, 2, 9'h007, 9, 0, 0, 0, 0));
    tv.push_back(mk(kn(10), 20, 24, 18'h1696A, 0, 1, 2, 9'h007, 9, 1, 0, 0, 0));
    // '#' mid-game keeps is_right; a two-key vector produces nothing.
    tv.push_back(mk(kn(11), 20, 24, 18'h00000, 0, 1, 0, 9'h000, 0, 1, 0, 0, 0));
    tv.push_back(mk(kn(5), 20, 24, 18'h00200, 0, 0, 0, 9'h000, 1, 1, 0, 0, 0));
    tv.push_back(mk(kn(12), 20, 24, 18'h00000, 1, 0, 0, 9'h000, 0, 1, 0, 1, 0));
    tv.push_back(mk(kn(11), 20, 24, 18'h00000, 0, 1, 0, 9'h000, 0, 1, 0, 0, 0));
    tv.push_back(mk(12'h003, 40, 24, 18'h00000, 0, 1, 0, 9'h000, 0, 1, 0, 0, 0));
    tv.push_back(mk(kn(1), 20, 24, 18'h00002, 0, 0, 0, 9'h000, 1, 1, 0, 0, 0));

    // Reset values, with '0' already held so the debouncer must stay disarmed.
    rst = 1'b1;
    key_data = kn(11);
    repeat (3) @(negedge clk);
    cmp("rst board", 32'(board), 32'h0);
    cmp("rst is_main", 32'(is_main), 32'h1);
    cmp("rst is_turn_o", 32'(is_turn_o), 32'h1);
    cmp("rst is_right", 32'(is_right), 32'h0);
    cmp("rst winner", 32'(winner), 32'h0);
    cmp("rst win_line", 32'(win_line), 32'h0);
    cmp("rst move_cnt", 32'(move_cnt), 32'h0);
    cmp("rst place_err", 32'(place_err), 32'h0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    cmp("held-through-reset is_main", 32'(is_main), 32'h1);

    // Idle, then '0' held for 40 cycles: one event, into PLAY.
    key_data = 12'h000;
    repeat (20) @(negedge clk);
    perr_start = perr_total;
    apply(kn(11), 40, 24);
    cmp("start is_main", 32'(is_main), 32'h0);
    cmp("start is_turn_o", 32'(is_turn_o), 32'h1);
    cmp("start board", 32'(board), 32'h0);
    cmp("start move_cnt", 32'(move_cnt), 32'h0);

    // Three short glitches on key 5, then a clean press with exact latency.
    for (int g = 0; g < 3; g++) begin
      key_data = kn(5);
      repeat (8) @(negedge clk);
      key_data = 12'h000;
      repeat (8) @(negedge clk);
    end
    cmp("glitch board", 32'(board), 32'h0);
    cmp("glitch move_cnt", 32'(move_cnt), 32'h0);
    key_data = kn(5);
    repeat (17) @(negedge clk);
    cmp("press5 board", 32'(board), 32'h00200);
    cmp("press5 move_cnt", 32'(move_cnt), 32'h1);
    cmp("press5 turn in CHECK", 32'(is_turn_o), 32'h1);
    @(negedge clk);
    cmp("press5 turn after CHECK", 32'(is_turn_o), 32'h0);
    repeat (2) @(negedge clk);
    key_data = 12'h000;
    repeat (24) @(negedge clk);
    cmp("press5 place_err", 32'(perr_total - perr_start), 32'h0);

    for (int i = 0; i < tv.size(); i++) begin
      perr_start = perr_total;
      apply(tv[i].key, tv[i].hold, tv[i].rel);
      check_vec($sformatf("v%0d", i), tv[i], perr_total - perr_start);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
